// File: rtl/oled_text_scheduler_if.sv
// oled_text_scheduler_if: user write port, font ROM port, OLED_interface command port and status
interface oled_text_scheduler_if #(
  parameter int CHAR_COLS  = 2,
  parameter int CHAR_ROWS  = 2,
  parameter int CHAR_W     = 8,
  parameter int GLYPH_BITS = 4
);
  localparam int NCELL = CHAR_COLS * CHAR_ROWS;
  localparam int AW    = $clog2(NCELL + 1);
  logic                  i_WR_EN;
  logic [AW-1:0]         i_WR_ADDR;
  logic [CHAR_W-1:0]     i_WR_DATA;
  logic                  i_REFRESH;
  logic [CHAR_W-1:0]     o_FONT_ADDR;
  logic [GLYPH_BITS-1:0] i_FONT_DATA;
  logic [1:0]            o_OLED_MODE;
  logic                  o_OLED_START;
  logic [GLYPH_BITS-1:0] o_OLED_PIXEL;
  logic                  i_OLED_READY;
  logic                  o_BUSY;
  logic                  o_FRAME_DONE;
  logic                  o_ERROR;
  modport master (
    input  i_WR_EN, i_WR_ADDR, i_WR_DATA, i_REFRESH, i_FONT_DATA, i_OLED_READY,
    output o_FONT_ADDR, o_OLED_MODE, o_OLED_START, o_OLED_PIXEL, o_BUSY, o_FRAME_DONE, o_ERROR
  );
  modport slave (
    output i_WR_EN, i_WR_ADDR, i_WR_DATA, i_REFRESH, i_FONT_DATA, i_OLED_READY,
    input  o_FONT_ADDR, o_OLED_MODE, o_OLED_START, o_OLED_PIXEL, o_BUSY, o_FRAME_DONE, o_ERROR
  );
endinterface

// File: rtl/oled_text_scheduler.sv
// oled_text_scheduler: power-on then full-grid redraws through OLED_interface, one glyph command per cell
module oled_text_scheduler #(
  parameter int CHAR_COLS   = 2,
  parameter int CHAR_ROWS   = 2,
  parameter int CHAR_W      = 8,
  parameter int GLYPH_BITS  = 4,
  parameter int REQ_TIMEOUT = 255
) (
  input  logic i_CLK,
  input  logic i_RST,
  oled_text_scheduler_if.master bus
);
  localparam int NCELL = CHAR_COLS * CHAR_ROWS;
  localparam int CW    = $clog2(NCELL);
  // one spare address bit so out-of-range cell indices are representable and can be rejected
  localparam int AW    = $clog2(NCELL + 1);
  localparam int TW    = $clog2(REQ_TIMEOUT + 1);
  localparam logic [2:0] BOOT     = 3'd0;
  localparam logic [2:0] PWR_REQ  = 3'd1;
  localparam logic [2:0] PWR_WAIT = 3'd2;
  localparam logic [2:0] IDLE     = 3'd3;
  localparam logic [2:0] FETCH    = 3'd4;
  localparam logic [2:0] LATCH    = 3'd5;
  localparam logic [2:0] REQ      = 3'd6;
  localparam logic [2:0] WAIT     = 3'd7;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [CHAR_W-1:0]     r_buf [NCELL];
  logic [CW-1:0]         r_cell;
  logic [TW-1:0]         r_cnt;
  logic                  r_dirty;
  logic                  r_done;
  logic                  r_error;
  logic [1:0]            r_mode;
  logic [GLYPH_BITS-1:0] r_pixel;
  logic                  w_wr;
  logic                  w_req;
  logic                  w_to;
  logic                  w_last;

  // write qualification, request/timeout detection and outputs derived from state
  always_comb begin
    w_wr              = bus.i_WR_EN && (bus.i_WR_ADDR < AW'(NCELL));
    w_req             = (r_state == PWR_REQ) || (r_state == REQ);
    w_to              = w_req && bus.i_OLED_READY && (r_cnt == TW'(REQ_TIMEOUT - 1));
    w_last            = r_cell == CW'(NCELL - 1);
    bus.o_OLED_START  = w_req;
    bus.o_BUSY        = r_state != IDLE;
    bus.o_FONT_ADDR   = r_buf[r_cell];
    bus.o_OLED_MODE   = r_mode;
    bus.o_OLED_PIXEL  = r_pixel;
    bus.o_FRAME_DONE  = r_done;
    bus.o_ERROR       = r_error;
  end

  // next state: READY falling wins over a timeout in the same cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      BOOT:     w_next = bus.i_OLED_READY ? PWR_REQ : BOOT;
      PWR_REQ:  w_next = !bus.i_OLED_READY ? PWR_WAIT : w_to ? BOOT : PWR_REQ;
      PWR_WAIT: w_next = bus.i_OLED_READY ? IDLE : PWR_WAIT;
      IDLE:     w_next = (r_dirty || bus.i_REFRESH) ? FETCH : IDLE;
      FETCH:    w_next = LATCH;
      LATCH:    w_next = REQ;
      REQ:      w_next = !bus.i_OLED_READY ? WAIT : w_to ? IDLE : REQ;
      WAIT:     w_next = bus.i_OLED_READY ? (w_last ? IDLE : FETCH) : WAIT;
      default:  w_next = BOOT;
    endcase
  end

  // character buffer, writable in any state
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      for (int i = 0; i < NCELL; i++) r_buf[i] <= '0;
    end else if (w_wr) begin
      r_buf[bus.i_WR_ADDR[CW-1:0]] <= bus.i_WR_DATA;
    end
  end

  // sequencer state, cell walk, timeout counter, command registers and status flags
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= BOOT;
      r_dirty <= 1'b1;
      r_cell  <= '0;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_pixel <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : w_req ? r_cnt + 1'b1 : r_cnt;
      r_dirty <= (w_wr || w_to) ? 1'b1 : (r_state == IDLE && w_next == FETCH) ? 1'b0 : r_dirty;
      r_cell  <= (r_state == IDLE) ? '0 : (r_state == WAIT && bus.i_OLED_READY && !w_last) ? r_cell + 1'b1 : r_cell;
      r_mode  <= (w_next == REQ) ? 2'b10 : (w_next == PWR_REQ) ? 2'b00 : r_mode;
      r_pixel <= (r_state == LATCH) ? bus.i_FONT_DATA : (w_next == PWR_REQ) ? '0 : r_pixel;
      r_done  <= (r_state == WAIT) && bus.i_OLED_READY && w_last;
      r_error <= r_error | w_to;
    end
  end
endmodule

// File: tb/tb_oled_text_scheduler.sv
// tb_oled_text_scheduler: OLED_interface and font ROM models with a command scoreboard
module tb_oled_text_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic stuck = 1'b0;
  logic prev_start = 1'b0;
  int   mcnt = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   cmd_idx = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  oled_text_scheduler_if bus();
  oled_text_scheduler dut (.i_CLK(clk), .i_RST(rst), .bus(bus));

  // display model: READY falls one cycle after START, comes back after four more cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.i_OLED_READY <= 1'b1;
      mcnt <= 0;
    end else if (!bus.i_OLED_READY) begin
      if (mcnt == 0) bus.i_OLED_READY <= 1'b1;
      else mcnt <= mcnt - 1;
    end else if (bus.o_OLED_START && !stuck) begin
      bus.i_OLED_READY <= 1'b0;
      mcnt <= 3;
    end
  end

  // font ROM model: one-cycle latency, glyph is the low nibble of the code
  always @(posedge clk) bus.i_FONT_DATA <= bus.o_FONT_ADDR[3:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every START rising edge pops one expected {mode,pixel}
  always @(negedge clk) begin
    if (bus.o_OLED_START && !prev_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_cmd: observed mode=%0b pixel=%0b expected no command", bus.o_OLED_MODE, bus.o_OLED_PIXEL);
      end else begin
        check("cmd", {bus.o_OLED_MODE, bus.o_OLED_PIXEL}, {26'd0, exp_q.pop_front()});
      end
      if (bus.o_OLED_MODE == 2'b10) cmd_idx++;
    end
    if (bus.o_FRAME_DONE) begin
      done_cnt++;
      cmd_idx = 0;
    end
    if (rst) cmd_idx = 0;
    prev_start = bus.o_OLED_START;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] p3);
    exp_q.push_back({2'b10, p0});
    exp_q.push_back({2'b10, p1});
    exp_q.push_back({2'b10, p2});
    exp_q.push_back({2'b10, p3});
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] data);
    bus.i_WR_EN = 1'b1;
    bus.i_WR_ADDR = addr;
    bus.i_WR_DATA = data;
    tick();
    bus.i_WR_EN = 1'b0;
  endtask

  task automatic refresh();
    bus.i_REFRESH = 1'b1;
    tick();
    bus.i_REFRESH = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int t = 0;
    while (done_cnt < target && t < 2000) begin
      tick();
      t++;
    end
    check(tag, done_cnt, target);
  endtask

  task automatic idle_checks(input string tag);
    tick(2);
    check({tag, "_busy"}, bus.o_BUSY, 1'b0);
    check({tag, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    int t;
    int n;
    logic busy_seen;
    rst = 1'b1;
    bus.i_WR_EN = 1'b0;
    bus.i_WR_ADDR = '0;
    bus.i_WR_DATA = '0;
    bus.i_REFRESH = 1'b0;
    tick(2);
    check("rst_start", bus.o_OLED_START, 1'b0);
    check("rst_mode", bus.o_OLED_MODE, 2'b00);
    check("rst_pixel", bus.o_OLED_PIXEL, 4'h0);
    check("rst_font", bus.o_FONT_ADDR, 8'h00);
    check("rst_done", bus.o_FRAME_DONE, 1'b0);
    check("rst_error", bus.o_ERROR, 1'b0);
    check("rst_busy", bus.o_BUSY, 1'b1);

    exp_q.push_back(6'b00_0000);
    push_frame(4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    wait_done(1, "boot_frame_done");
    idle_checks("boot");

    push_frame(4'h0, 4'h0, 4'hA, 4'h0);
    wr(3'd2, 8'h0A);
    wait_done(2, "wr2_frame_done");
    idle_checks("wr2");

    push_frame(4'h0, 4'h0, 4'hA, 4'h5);
    push_frame(4'h0, 4'h0, 4'hA, 4'h5);
    refresh();
    t = 0;
    while (!(cmd_idx == 2 && !bus.o_OLED_START && !bus.i_OLED_READY) && t < 200) begin
      tick();
      t++;
    end
    check("cell1_wait_reached", t < 200, 1'b1);
    wr(3'd3, 8'h05);
    wait_done(4, "midframe_done");
    tick(20);
    check("midframe_no_extra", done_cnt, 4);
    idle_checks("midframe");

    wr(3'd4, 8'h33);
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      busy_seen |= bus.o_BUSY;
      tick();
    end
    check("oor_busy", busy_seen, 1'b0);
    check("oor_done", done_cnt, 4);

    stuck = 1'b1;
    exp_q.push_back(6'b10_0000);
    push_frame(4'h0, 4'h0, 4'hA, 4'h5);
    refresh();
    t = 0;
    while (!bus.o_OLED_START && t < 50) begin
      tick();
      t++;
    end
    n = 0;
    while (bus.o_OLED_START && n < 400) begin
      n++;
      tick();
    end
    stuck = 1'b0;
    check("timeout_len", n, 255);
    check("timeout_start", bus.o_OLED_START, 1'b0);
    check("timeout_error", bus.o_ERROR, 1'b1);
    wait_done(5, "post_timeout_done");
    check("error_sticky", bus.o_ERROR, 1'b1);
    idle_checks("post_timeout");

    exp_q.push_back(6'b10_0000);
    exp_q.push_back(6'b10_0000);
    refresh();
    t = 0;
    while (!(cmd_idx == 2 && bus.o_OLED_START) && t < 200) begin
      tick();
      t++;
    end
    check("cell1_req_reached", t < 200, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_start", bus.o_OLED_START, 1'b0);
    check("midrst_mode", bus.o_OLED_MODE, 2'b00);
    check("midrst_pixel", bus.o_OLED_PIXEL, 4'h0);
    check("midrst_font", bus.o_FONT_ADDR, 8'h00);
    check("midrst_error", bus.o_ERROR, 1'b0);
    check("midrst_busy", bus.o_BUSY, 1'b1);
    check("midrst_queue", exp_q.size(), 0);
    exp_q.push_back(6'b00_0000);
    push_frame(4'h0, 4'h0, 4'h0, 4'h0);
    tick(2);
    rst = 1'b0;
    wait_done(6, "rst_frame_done");
    check("rst_error_clear", bus.o_ERROR, 1'b0);
    idle_checks("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
